// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and the request record
// carried from the issue queue to the ALU.
package alu_pkg;

  localparam logic [2:0] ALU_OP_ADD     = 3'd0;
  localparam logic [2:0] ALU_OP_SUB     = 3'd1;
  localparam logic [2:0] ALU_OP_SRL     = 3'd2;
  localparam logic [2:0] ALU_OP_SLL     = 3'd3;
  localparam logic [2:0] ALU_OP_LT      = 3'd4;
  localparam logic [2:0] ALU_OP_EQ      = 3'd5;
  localparam logic [2:0] ALU_OP_GT      = 3'd6;
  localparam logic [2:0] ALU_OP_INVALID = 3'd7;

  typedef struct packed {
    logic [7:0] in0;
    logic [7:0] in1;
    logic [2:0] op;
  } alu_req_t;

endpackage

// File: rtl/alu_req_queue.sv
// In-order request FIFO with wrap-around pointers and an occupancy count.
// p_depth must be a power of two (2 or 4) so the pointers wrap naturally.
module alu_req_queue
  import alu_pkg::*;
#(
  parameter int p_depth = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enq_val,
  output logic                     enq_rdy,
  input  alu_req_t                 enq_data,
  output logic                     deq_val,
  input  logic                     deq_rdy,
  output alu_req_t                 deq_data,
  output logic [$clog2(p_depth):0] count
);

  localparam int PW = $clog2(p_depth);
  localparam int CW = PW + 1;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  alu_req_t      r_mem [p_depth];
  logic          w_enq;
  logic          w_deq;

  assign enq_rdy  = (r_count != CW'(p_depth));
  assign deq_val  = (r_count != '0);
  assign deq_data = r_mem[r_rd_ptr];
  assign count    = r_count;
  assign w_enq    = enq_val && enq_rdy;
  assign w_deq    = deq_val && deq_rdy;

  // Storage is not reset; the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem[r_wr_ptr] <= enq_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/seq_arith_8b_alu_issue.sv
// Issue/writeback wrapper: queues ALU requests, presents the head to the
// external combinational ALU and registers its result as the response.
module seq_arith_8b_alu_issue
  import alu_pkg::*;
#(
  parameter int p_depth = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_val,
  output logic       req_rdy,
  input  logic [7:0] req_in0,
  input  logic [7:0] req_in1,
  input  logic [2:0] req_op,
  output logic [7:0] alu_in0,
  output logic [7:0] alu_in1,
  output logic [2:0] alu_op,
  input  logic [7:0] alu_out,
  output logic       resp_val,
  input  logic       resp_rdy,
  output logic [7:0] resp_out
);

  alu_req_t                 w_enq_data;
  alu_req_t                 w_head;
  logic                     w_enq_rdy;
  logic                     w_deq_val;
  logic [$clog2(p_depth):0] w_count;
  logic                     w_issue;
  logic                     r_resp_val;
  logic [7:0]               r_resp_out;

  assign w_enq_data = {req_in0, req_in1, req_op};
  // Ready depends only on occupancy, never on a same-cycle dequeue.
  assign req_rdy    = !reset && w_enq_rdy;
  assign w_issue    = (w_count != '0) && (!r_resp_val || resp_rdy);

  alu_req_queue #(
    .p_depth (p_depth)
  ) u_queue (
    .clk      (clk),
    .reset    (reset),
    .enq_val  (req_val && req_rdy),
    .enq_rdy  (w_enq_rdy),
    .enq_data (w_enq_data),
    .deq_val  (w_deq_val),
    .deq_rdy  (w_issue),
    .deq_data (w_head),
    .count    (w_count)
  );

  assign alu_in0 = (w_deq_val && !reset) ? w_head.in0 : '0;
  assign alu_in1 = (w_deq_val && !reset) ? w_head.in1 : '0;
  assign alu_op  = (w_deq_val && !reset) ? w_head.op  : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_resp_val <= 1'b0;
      r_resp_out <= '0;
    end else if (w_issue) begin
      r_resp_val <= 1'b1;
      r_resp_out <= alu_out;
    end else if (r_resp_val && resp_rdy) begin
      r_resp_val <= 1'b0;
    end
  end

  // Masked during reset so nothing stale is visible before the reset edge lands.
  assign resp_val = r_resp_val && !reset;
  assign resp_out = reset ? 8'd0 : r_resp_out;

endmodule

// File: tb/tb_seq_arith_8b_alu_issue.sv
// Scoreboard bench: accepted requests push an expected result, a negedge
// monitor pops and compares on every response handshake.
module tb_seq_arith_8b_alu_issue;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_val;
  logic       req_rdy;
  logic [7:0] req_in0;
  logic [7:0] req_in1;
  logic [2:0] req_op;
  logic [7:0] alu_in0;
  logic [7:0] alu_in1;
  logic [2:0] alu_op;
  logic [7:0] alu_out;
  logic       resp_val;
  logic       resp_rdy;
  logic [7:0] resp_out;

  logic [7:0] tb_exp;
  logic [7:0] exp_q [$];
  int         n_checks = 0;
  int         n_pass   = 0;

  always #5 clk = ~clk;

  seq_arith_8b_alu_issue #(.p_depth(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_val  (req_val),
    .req_rdy  (req_rdy),
    .req_in0  (req_in0),
    .req_in1  (req_in1),
    .req_op   (req_op),
    .alu_in0  (alu_in0),
    .alu_in1  (alu_in1),
    .alu_op   (alu_op),
    .alu_out  (alu_out),
    .resp_val (resp_val),
    .resp_rdy (resp_rdy),
    .resp_out (resp_out)
  );

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op);
    logic [7:0] r;
    r = 8'd0;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a >> b;
      3'd3: r = a << b;
      3'd4: r = {7'd0, a < b};
      3'd5: r = {7'd0, a == b};
      3'd6: r = {7'd0, a > b};
      default: r = 8'd0;
    endcase
    return r;
  endfunction

  // Behavioural ALU sitting downstream of the wrapper's operand ports.
  assign alu_out = alu_f(alu_in0, alu_in1, alu_op);

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (resp_val === 1'b1 && resp_rdy) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL resp_unexpected: got %0d expected no response", resp_out);
      end else begin
        chk8("resp_out", resp_out, exp_q.pop_front());
      end
    end
    if (!reset && req_val && req_rdy) exp_q.push_back(tb_exp);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Holds the request until accepted, returns just after the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input logic [7:0] e);
    logic ok;
    ok      = 1'b0;
    req_in0 = a;
    req_in1 = b;
    req_op  = op;
    tb_exp  = e;
    req_val = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    chk1("send_accept", ok, 1'b1);
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_val = 1'b0; resp_rdy = 1'b0;
    req_in0 = 8'd0; req_in1 = 8'd0; req_op = 3'd0; tb_exp = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_req_rdy", req_rdy, 1'b0);
    chk1("rst_resp_val", resp_val, 1'b0);
    chk8("rst_resp_out", resp_out, 8'd0);
    chk8("rst_alu_in0", alu_in0, 8'd0);
    chk8("rst_alu_in1", alu_in1, 8'd0);
    chk8("rst_alu_op", {5'd0, alu_op}, 8'd0);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk1("post_rst_req_rdy", req_rdy, 1'b1);
    cyc();

    // Single request: 42+13, response two cycles after acceptance.
    resp_rdy = 1'b1;
    send(8'd42, 8'd13, 3'd0, 8'd55);
    req_val = 1'b0;
    @(negedge clk);
    chk8("single_alu_in0", alu_in0, 8'd42);
    chk8("single_alu_in1", alu_in1, 8'd13);
    chk8("single_alu_op", {5'd0, alu_op}, 8'd0);
    chk1("single_resp_n1", resp_val, 1'b0);
    @(negedge clk);
    chk1("single_resp_n2", resp_val, 1'b1);
    @(negedge clk);
    chk1("single_resp_n3", resp_val, 1'b0);
    cyc();

    // Back-to-back at full throughput.
    send(8'd42, 8'd9, 3'd1, 8'd33);
    send(8'd13, 8'd2, 3'd2, 8'd3);
    send(8'd13, 8'd2, 3'd3, 8'd52);
    send(8'd1, 8'd2, 3'd4, 8'd1);
    req_val = 1'b0;
    @(negedge clk);
    chk1("b2b_resp_3", resp_val, 1'b1);
    @(negedge clk);
    chk1("b2b_resp_4", resp_val, 1'b1);
    @(negedge clk);
    chk1("b2b_idle", resp_val, 1'b0);
    cyc();

    // Backpressure: two queued plus one held in the response register.
    resp_rdy = 1'b0;
    send(8'd5, 8'd3, 3'd0, 8'd8);
    send(8'd200, 8'd100, 3'd0, 8'd44);
    send(8'd3, 8'd5, 3'd1, 8'd254);
    req_in0 = 8'd16; req_in1 = 8'd1; req_op = 3'd2; tb_exp = 8'd8; req_val = 1'b1;
    @(negedge clk);
    chk1("bp_full_rdy", req_rdy, 1'b0);
    chk1("bp_resp_held", resp_val, 1'b1);
    cyc();
    @(negedge clk);
    chk1("bp_full_rdy2", req_rdy, 1'b0);
    chk8("bp_accepted", 8'(exp_q.size()), 8'd3);
    cyc();
    resp_rdy = 1'b1;
    @(negedge clk);
    chk1("bp_drain_cycle_rdy", req_rdy, 1'b0);
    @(negedge clk);
    chk1("bp_after_drain_rdy", req_rdy, 1'b1);
    cyc();
    req_val = 1'b0;
    repeat (5) cyc();

    // Invalid opcode passes through; comparisons produce 0/1.
    send(8'd2, 8'd1, 3'd7, 8'd0);
    send(8'd2, 8'd1, 3'd6, 8'd1);
    send(8'd1, 8'd1, 3'd5, 8'd1);
    req_val = 1'b0;
    repeat (5) cyc();

    // Reset with a response pending and two requests queued.
    resp_rdy = 1'b0;
    send(8'd7, 8'd7, 3'd0, 8'd14);
    send(8'd9, 8'd1, 3'd1, 8'd8);
    send(8'd4, 8'd4, 3'd5, 8'd1);
    req_val = 1'b0;
    @(negedge clk);
    chk1("pre_rst_resp_val", resp_val, 1'b1);
    chk1("pre_rst_req_rdy", req_rdy, 1'b0);
    cyc();
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk1("mid_rst_resp_val", resp_val, 1'b0);
    chk1("mid_rst_req_rdy", req_rdy, 1'b0);
    cyc();
    reset = 1'b0;
    resp_rdy = 1'b1;
    @(negedge clk);
    chk1("after_rst_req_rdy", req_rdy, 1'b1);
    chk8("after_rst_alu_in0", alu_in0, 8'd0);
    chk8("after_rst_alu_in1", alu_in1, 8'd0);
    chk8("after_rst_alu_op", {5'd0, alu_op}, 8'd0);
    for (int i = 0; i < 3; i++) begin
      chk1("after_rst_no_stale", resp_val, 1'b0);
      @(negedge clk);
    end
    cyc();

    // Random traffic against the behavioural model.
    for (int i = 0; i < 200; i++) begin
      req_val  = 1'($urandom_range(0, 1));
      resp_rdy = 1'($urandom_range(0, 3) != 0);
      req_in0  = 8'($urandom_range(0, 255));
      req_in1  = (i % 3 == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom_range(0, 255));
      req_op   = 3'($urandom_range(0, 7));
      tb_exp   = alu_f(req_in0, req_in1, req_op);
      cyc();
    end
    req_val  = 1'b0;
    resp_rdy = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
    chk8("drain_empty", 8'(exp_q.size()), 8'd0);
    repeat (2) cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
